tlcd_ram_reader: RTL and testbench

//   Read-side engine for the HD44780-style text LCD. Sets a CGRAM or DDRAM address, then reads

---
 rtl/tlcd_pkg.sv | 34 +++
 rtl/tlcd_ram_reader_if.sv | 28 ++
 rtl/tlcd_bus_cycle.sv | 89 ++++++++
 rtl/tlcd_ram_reader.sv | 134 +++++++++++++
 tb/tb_tlcd_ram_reader.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlcd_pkg.sv
// Shared constants and state types for the TLCD engines.
// Used by the RAM reader, font loader and text writers.
package tlcd_pkg;

  localparam logic [7:0] CMD_SET_CGRAM = 8'h40;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam int         BF_BIT        = 7;
  localparam logic [6:0] MAX_LEN       = 7'd80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_POLL,
    S_READ,
    S_FIN
  } rd_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_SETUP,
    B_PULSE,
    B_HOLD
  } bus_state_t;

  function automatic logic [7:0] addr_cmd(
    input logic       space,
    input logic [6:0] addr
  );
    if (space)
      return CMD_SET_CGRAM | {2'b00, addr[5:0]};
    return CMD_SET_DDRAM | {1'b0, addr};
  endfunction

endpackage

// File: rtl/tlcd_ram_reader_if.sv
// TLCD pin bundle between a bus engine and the LCD pad ring.
// The tristate buffer itself is built at the top level.
interface tlcd_ram_reader_if;
  logic       TLCD_E;
  logic       TLCD_RS;
  logic       TLCD_RW;
  logic [7:0] TLCD_DATA_OUT;
  logic       TLCD_DATA_OE;
  logic [7:0] TLCD_DATA_IN;

  modport master (
    output TLCD_E,
    output TLCD_RS,
    output TLCD_RW,
    output TLCD_DATA_OUT,
    output TLCD_DATA_OE,
    input  TLCD_DATA_IN
  );

  modport slave (
    input  TLCD_E,
    input  TLCD_RS,
    input  TLCD_RW,
    input  TLCD_DATA_OUT,
    input  TLCD_DATA_OE,
    output TLCD_DATA_IN
  );
endinterface

// File: rtl/tlcd_bus_cycle.sv
// One TLCD bus operation: SETUP (E=0), PULSE (E=1), HOLD (E=0).
// RS/RW/data are latched when the op is launched and held after it.
module tlcd_bus_cycle
  import tlcd_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int E_HIGH_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       go,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] wdata,
  input  logic [7:0] din,
  output logic       e,
  output logic       oe,
  output logic       bus_rs,
  output logic       bus_rw,
  output logic [7:0] bus_data,
  output logic [7:0] rdata,
  output logic       idle,
  output logic       op_done
);

  bus_state_t st, st_n;
  logic [7:0] cnt, cnt_n;
  logic       last;

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    last  = 1'b0;
    unique case (st)
      B_IDLE:
        if (go) begin
          st_n  = B_SETUP;
          cnt_n = '0;
        end
      B_SETUP:
        if (cnt == 8'(SETUP_CYCLES - 1)) begin
          st_n  = B_PULSE;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      B_PULSE:
        if (cnt == 8'(E_HIGH_CYCLES - 1)) begin
          st_n = B_HOLD;
          last = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      B_HOLD:  st_n = B_IDLE;
      default: st_n = B_IDLE;
    endcase
  end

  // OE only ever follows a write launch, so it can never overlap RW=1
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      st       <= B_IDLE;
      cnt      <= '0;
      bus_rs   <= 1'b0;
      bus_rw   <= 1'b1;
      bus_data <= '0;
      oe       <= 1'b0;
      rdata    <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
      if (st == B_IDLE && go) begin
        bus_rs   <= rs;
        bus_rw   <= rw;
        bus_data <= wdata;
        oe       <= !rw;
      end else if (st == B_HOLD) begin
        oe <= 1'b0;
      end
      if (last && bus_rw)
        rdata <= din;
    end
  end

  assign e       = (st == B_PULSE);
  assign idle    = (st == B_IDLE);
  assign op_done = (st == B_HOLD);

endmodule

// File: rtl/tlcd_ram_reader.sv
// Reads LENGTH bytes of CGRAM/DDRAM back over the TLCD bus,
// polling the busy flag before every read and after the last one.
module tlcd_ram_reader
  import tlcd_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int E_HIGH_CYCLES = 2,
  parameter int BUSY_TIMEOUT  = 255
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       START,
  input  logic       SPACE,
  input  logic [6:0] START_ADDR,
  input  logic [6:0] LENGTH,
  output logic       BUSY,
  output logic       RD_VALID,
  output logic [7:0] RD_DATA,
  output logic [6:0] RD_INDEX,
  output logic       DONE,
  output logic       ERR,
  tlcd_ram_reader_if.master tlcd
);

  rd_state_t  st, st_n;
  logic [7:0] cmd_q;
  logic [6:0] len_q;
  logic [7:0] poll_q, poll_n;
  logic [6:0] idx_n;
  logic       err_n;
  logic       go, rs, rw;
  logic [7:0] wdata, rdata;
  logic       bidle, op_done, bf;

  assign bf = rdata[BF_BIT];

  always_comb begin
    st_n   = st;
    poll_n = poll_q;
    idx_n  = RD_INDEX;
    err_n  = ERR;
    go     = 1'b0;
    rs     = 1'b0;
    rw     = 1'b1;
    wdata  = '0;
    unique case (st)
      S_IDLE:
        if (START) begin
          st_n   = S_CMD;
          idx_n  = '0;
          err_n  = 1'b0;
          poll_n = '0;
        end
      S_CMD: begin
        go    = bidle;
        rw    = 1'b0;
        wdata = cmd_q;
        if (op_done)
          st_n = S_POLL;
      end
      S_POLL: begin
        go = bidle;
        if (op_done) begin
          if (!bf) begin
            poll_n = '0;
            st_n   = (RD_INDEX == len_q) ? S_FIN : S_READ;
          end else if (poll_q == 8'(BUSY_TIMEOUT - 1)) begin
            err_n = 1'b1;
            st_n  = S_FIN;
          end else begin
            poll_n = poll_q + 8'd1;
          end
        end
      end
      S_READ: begin
        go = bidle;
        rs = 1'b1;
        if (op_done) begin
          idx_n = RD_INDEX + 7'd1;
          st_n  = S_POLL;
        end
      end
      S_FIN:   st_n = S_IDLE;
      default: st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      st       <= S_IDLE;
      poll_q   <= '0;
      RD_INDEX <= '0;
      ERR      <= 1'b0;
      cmd_q    <= '0;
      len_q    <= '0;
    end else begin
      st       <= st_n;
      poll_q   <= poll_n;
      RD_INDEX <= idx_n;
      ERR      <= err_n;
      if (st == S_IDLE && START) begin
        cmd_q <= addr_cmd(SPACE, START_ADDR);
        len_q <= (LENGTH > MAX_LEN) ? MAX_LEN : LENGTH;
      end
    end
  end

  assign BUSY     = (st != S_IDLE) && (st != S_FIN);
  assign DONE     = (st == S_FIN);
  assign RD_VALID = op_done && (st == S_READ);
  assign RD_DATA  = rdata;

  tlcd_bus_cycle #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .E_HIGH_CYCLES(E_HIGH_CYCLES)
  ) u_bus (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .go      (go),
    .rs      (rs),
    .rw      (rw),
    .wdata   (wdata),
    .din     (tlcd.TLCD_DATA_IN),
    .e       (tlcd.TLCD_E),
    .oe      (tlcd.TLCD_DATA_OE),
    .bus_rs  (tlcd.TLCD_RS),
    .bus_rw  (tlcd.TLCD_RW),
    .bus_data(tlcd.TLCD_DATA_OUT),
    .rdata   (rdata),
    .idle    (bidle),
    .op_done (op_done)
  );

endmodule

// File: tb/tb_tlcd_ram_reader.sv
// Bench for tlcd_ram_reader: HD44780 bus model with CGRAM/DDRAM,
// address counter and programmable busy flag.
module tb_tlcd_ram_reader;

  localparam int TMO = 6;

  typedef struct {
    bit       space;
    bit [6:0] addr;
    bit [6:0] len;
    int       bf;
    bit       stuck;
    bit [7:0] exp_cmd;
    int       exp_n;
    int       exp_polls;
    bit       exp_err;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       START = 1'b0;
  logic       SPACE = 1'b0;
  logic [6:0] START_ADDR = '0;
  logic [6:0] LENGTH = '0;
  logic       BUSY, RD_VALID, DONE, ERR;
  logic [7:0] RD_DATA;
  logic [6:0] RD_INDEX;

  tlcd_ram_reader_if tlcd ();

  tlcd_ram_reader #(
    .SETUP_CYCLES (1),
    .E_HIGH_CYCLES(2),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .START     (START),
    .SPACE     (SPACE),
    .START_ADDR(START_ADDR),
    .LENGTH    (LENGTH),
    .BUSY      (BUSY),
    .RD_VALID  (RD_VALID),
    .RD_DATA   (RD_DATA),
    .RD_INDEX  (RD_INDEX),
    .DONE      (DONE),
    .ERR       (ERR),
    .tlcd      (tlcd)
  );

  always #5 CLK = ~CLK;

  // LCD model state
  logic [7:0] cgram [64];
  logic [7:0] ddram [128];
  logic [6:0] ac = '0;
  bit         cg = 1'b0;
  int         bf_left = 0;
  bit         bf_stuck = 1'b0;
  logic [7:0] din;

  always_comb begin
    din = 8'h00;
    if (tlcd.TLCD_RW) begin
      if (!tlcd.TLCD_RS)
        din = {(bf_stuck || bf_left != 0), ac};
      else
        din = cg ? cgram[ac[5:0]] : ddram[ac];
    end
  end
  assign tlcd.TLCD_DATA_IN = din;

  // observed traffic
  logic [7:0] cmd_log [$];
  byte        ops [$];
  int         rv_idx [$];
  logic [7:0] rv_dat [$];
  int         done_cnt = 0;
  int         prot_viol = 0;
  int         checks = 0;
  int         errors = 0;

  initial begin
    logic e_q, rs_q, rw_q;
    e_q = 0; rs_q = 0; rw_q = 1;
    forever begin
      @(negedge CLK);
      if (RESETN) begin
        if (tlcd.TLCD_DATA_OE && tlcd.TLCD_RW) begin
          prot_viol++;
          $display("protocol: OE with RW=1 at %0t", $time);
        end
        if (tlcd.TLCD_E && e_q &&
            (tlcd.TLCD_RS !== rs_q || tlcd.TLCD_RW !== rw_q)) begin
          prot_viol++;
          $display("protocol: RS/RW moved with E=1 at %0t", $time);
        end
        if (tlcd.TLCD_E && !tlcd.TLCD_RW && !tlcd.TLCD_DATA_OE) begin
          prot_viol++;
          $display("protocol: write without OE at %0t", $time);
        end
        if (e_q && !tlcd.TLCD_E) begin
          if (!tlcd.TLCD_RW) begin
            cmd_log.push_back(tlcd.TLCD_DATA_OUT);
            ops.push_back("C");
            if (tlcd.TLCD_DATA_OUT[7]) begin
              cg = 1'b0;
              ac = tlcd.TLCD_DATA_OUT[6:0];
            end else if (tlcd.TLCD_DATA_OUT[6]) begin
              cg = 1'b1;
              ac = {1'b0, tlcd.TLCD_DATA_OUT[5:0]};
            end
          end else if (!tlcd.TLCD_RS) begin
            ops.push_back("P");
            if (bf_left > 0) bf_left--;
          end else begin
            ops.push_back("R");
            ac = cg ? {1'b0, ac[5:0] + 6'd1} : ac + 7'd1;
          end
        end
        if (RD_VALID) begin
          rv_idx.push_back(int'(RD_INDEX));
          rv_dat.push_back(RD_DATA);
        end
        if (DONE) done_cnt++;
      end
      e_q  = tlcd.TLCD_E;
      rs_q = tlcd.TLCD_RS;
      rw_q = tlcd.TLCD_RW;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input bit sp, input int a,
                                          input int i);
    if (sp) return cgram[(a % 64 + i) % 64];
    return ddram[(a + i) % 128];
  endfunction

  task automatic clear_logs();
    cmd_log.delete();
    ops.delete();
    rv_idx.delete();
    rv_dat.delete();
    done_cnt = 0;
  endtask

  task automatic kick(input bit sp, input bit [6:0] a, input bit [6:0] l);
    SPACE = sp;
    START_ADDR = a;
    LENGTH = l;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (DONE) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
  endtask

  function automatic int data_bad(input bit sp, input int a);
    int bad = 0;
    for (int i = 0; i < rv_idx.size(); i++)
      if (rv_idx[i] != i || rv_dat[i] !== exp_byte(sp, a, i)) bad++;
    return bad;
  endfunction

  function automatic logic [7:0] first_cmd();
    if (cmd_log.size() == 0) return 8'hxx;
    return cmd_log[0];
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    bit ok;
    int np, npf, nr;
    bit seen_r;
    clear_logs();
    bf_left = v.bf;
    bf_stuck = v.stuck;
    kick(v.space, v.addr, v.len);
    chk($sformatf("%s.busy", tag), BUSY, 1);
    wait_done(ok);
    chk($sformatf("%s.done", tag), ok, 1);
    chk($sformatf("%s.err", tag), ERR, v.exp_err);
    @(posedge CLK); #1;
    bf_stuck = 1'b0;
    chk($sformatf("%s.done_pulse", tag), DONE, 0);
    chk($sformatf("%s.idle", tag), BUSY, 0);
    chk($sformatf("%s.err_sticky", tag), ERR, v.exp_err);
    chk($sformatf("%s.done_cnt", tag), done_cnt, 1);
    np = 0; npf = 0; nr = 0; seen_r = 0;
    foreach (ops[i]) begin
      if (ops[i] == "P") begin
        np++;
        if (!seen_r) npf++;
      end
      if (ops[i] == "R") begin
        nr++;
        seen_r = 1;
      end
    end
    chk($sformatf("%s.ncmd", tag), cmd_log.size(), 1);
    chk($sformatf("%s.cmd", tag), first_cmd(), v.exp_cmd);
    chk($sformatf("%s.reads", tag), nr, v.exp_n);
    chk($sformatf("%s.valids", tag), rv_idx.size(), v.exp_n);
    chk($sformatf("%s.polls", tag), np, v.exp_polls);
    if (v.exp_n > 0)
      chk($sformatf("%s.poll_first", tag), npf, v.bf + 1);
    chk($sformatf("%s.data", tag), data_bad(v.space, v.addr), 0);
  endtask

  vec_t tbl [8];
  logic [7:0] font [8];

  initial begin
    bit ok;
    vec_t v;
    int lc;

    font[0] = 8'h06; font[1] = 8'h07; font[2] = 8'h04; font[3] = 8'h06;
    font[4] = 8'h0C; font[5] = 8'h1C; font[6] = 8'h1C; font[7] = 8'h14;
    for (int i = 0; i < 64; i++) cgram[i] = 8'($urandom);
    for (int i = 0; i < 128; i++) ddram[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) cgram[i] = font[i];

    //         sp addr    len     bf st cmd    n   polls err
    tbl[0] = '{1, 7'h00, 7'd8,   0, 0, 8'h40, 8,  9,  0};
    tbl[1] = '{0, 7'h45, 7'd0,   0, 0, 8'hC5, 0,  1,  0};
    tbl[2] = '{0, 7'h00, 7'd4,   5, 0, 8'h80, 4,  10, 0};
    tbl[3] = '{1, 7'h3C, 7'd8,   0, 0, 8'h7C, 8,  9,  0};
    tbl[4] = '{0, 7'h0A, 7'd100, 0, 0, 8'h8A, 80, 81, 0};
    tbl[5] = '{0, 7'h14, 7'd5,   0, 1, 8'h94, 0,  TMO, 1};
    tbl[6] = '{0, 7'h03, 7'd2,   1, 0, 8'h83, 2,  4,  0};
    tbl[7] = '{1, 7'h45, 7'd3,   0, 0, 8'h45, 3,  4,  0};

    repeat (3) @(posedge CLK);
    #1;
    chk("rst.E", tlcd.TLCD_E, 0);
    chk("rst.RS", tlcd.TLCD_RS, 0);
    chk("rst.RW", tlcd.TLCD_RW, 1);
    chk("rst.DOUT", tlcd.TLCD_DATA_OUT, 0);
    chk("rst.OE", tlcd.TLCD_DATA_OE, 0);
    chk("rst.BUSY", BUSY, 0);
    chk("rst.RD_VALID", RD_VALID, 0);
    chk("rst.RD_DATA", RD_DATA, 0);
    chk("rst.RD_INDEX", RD_INDEX, 0);
    chk("rst.DONE", DONE, 0);
    chk("rst.ERR", ERR, 0);
    RESETN = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end

    for (int i = 0; i < 8; i++)
      run_vec($sformatf("v%0d", i), tbl[i]);

    lc = 0;
    for (int i = 0; i < 8; i++)
      if (rv_dat.size() == 3 && i < 3 && rv_dat[i] !== font[5 + i]) lc++;
    chk("v7.font", lc, 0);

    for (int i = 0; i < 64; i++) cgram[i] = 8'($urandom);
    for (int i = 0; i < 128; i++) ddram[i] = 8'($urandom);
    for (int t = 0; t < 20; t++) begin
      v.space = 1'($urandom_range(0, 1));
      v.addr  = 7'($urandom_range(0, 127));
      v.len   = 7'($urandom_range(0, 90));
      v.bf    = int'($urandom_range(0, 4));
      v.stuck = 1'b0;
      lc = (v.len > 80) ? 80 : int'(v.len);
      v.exp_cmd = v.space ? 8'(64 + v.addr % 64) : 8'(128 + v.addr);
      v.exp_n = lc;
      v.exp_polls = lc + 1 + v.bf;
      v.exp_err = 1'b0;
      run_vec($sformatf("r%0d", t), v);
    end

    // START while busy, then in the DONE cycle, then one cycle later
    clear_logs();
    bf_left = 0;
    kick(0, 7'h10, 7'd6);
    chk("s6.busy", BUSY, 1);
    repeat (10) begin @(posedge CLK); #1; end
    SPACE = 1; START_ADDR = 7'h00; LENGTH = 7'd3; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(ok);
    chk("s6.done1", ok, 1);
    SPACE = 1; START_ADDR = 7'h02; LENGTH = 7'd2; START = 1'b1;
    @(posedge CLK); #1;
    chk("s6.done_ignore", BUSY, 0);
    chk("s6.n1", rv_idx.size(), 6);
    chk("s6.ncmd1", cmd_log.size(), 1);
    chk("s6.cmd1", first_cmd(), 8'h90);
    chk("s6.data1", data_bad(0, 7'h10), 0);
    clear_logs();
    @(posedge CLK); #1;
    START = 1'b0;
    chk("s6.accept", BUSY, 1);
    wait_done(ok);
    chk("s6.done2", ok, 1);
    @(posedge CLK); #1;
    chk("s6.cmd2", first_cmd(), 8'h42);
    chk("s6.n2", rv_idx.size(), 2);
    chk("s6.data2", data_bad(1, 7'h02), 0);
    chk("s6.done_cnt", done_cnt, 1);

    // reset in the middle of a READ pulse
    clear_logs();
    kick(0, 7'h00, 7'd8);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge CLK); #1;
      if (tlcd.TLCD_E && tlcd.TLCD_RS) ok = 1'b1;
    end
    chk("s5.reach_read", ok, 1);
    #1 RESETN = 1'b0;
    #1;
    chk("s5.E", tlcd.TLCD_E, 0);
    chk("s5.RW", tlcd.TLCD_RW, 1);
    chk("s5.OE", tlcd.TLCD_DATA_OE, 0);
    chk("s5.BUSY", BUSY, 0);
    chk("s5.DONE", DONE, 0);
    chk("s5.RD_VALID", RD_VALID, 0);
    repeat (2) @(posedge CLK);
    #1 RESETN = 1'b1;
    repeat (6) begin @(posedge CLK); #1; end
    chk("s5.no_done", done_cnt, 0);
    chk("s5.no_valid", rv_idx.size(), 0);
    chk("s5.idle", BUSY, 0);
    run_vec("s5.after", tbl[6]);

    chk("protocol", prot_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
